// File: rtl/pool_pkg.sv
// pool_pkg: shared sample-width, FSM state type and pool-size legality check for the pooling/unpooling stages
package pool_pkg;
  typedef enum logic {IDLE, EMIT} state_t;
  localparam int WIDTH_DATA_DEF = 16;
  localparam int WIDTH_KERNEL_DEF = 8;
  localparam int SAMPLE_W_DEF = WIDTH_DATA_DEF + WIDTH_KERNEL_DEF + 4;
  function automatic int sample_w(input int wd, input int wk);
    return wd + wk + 4;
  endfunction
  function automatic bit pool_size_ok(input int p);
    return p >= 2 && p <= 16;
  endfunction
endpackage

// File: rtl/unpool_fifo2.sv
// unpool_fifo2: 2-entry FIFO; ports clk, rstn (async low), push_i, pop_i, data_i -> data_o (head), count_o
module unpool_fifo2 #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] mem_q [2];
  logic         wr_q, rd_q;
  logic [1:0]   count_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q <= ~wr_q;
      end
      if (pop_i) rd_q <= ~rd_q;
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  assign data_o = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/unpool_11.sv
// unpool_11: nearest-neighbour unpooling, each input sample expands into POOL_SIZE output beats (valid/ready both sides); clk, rstn async low; UNPOOL_ZERO_FILL_EN makes beats 1.. carry 0
module unpool_11
  import pool_pkg::*;
#(
  parameter int WIDTH_DATA = 16,
  parameter int WIDTH_KERNEL = 8,
  parameter int POOL_SIZE = 4,
  localparam int W = sample_w(WIDTH_DATA, WIDTH_KERNEL)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         last_o
);
  localparam int CW = $clog2(POOL_SIZE);
  localparam logic [CW-1:0] LAST = CW'(POOL_SIZE - 1);
  if (!pool_size_ok(POOL_SIZE)) begin : g_bad_pool
    $error("POOL_SIZE must be in 2..16");
  end
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  hold_q, hold_d, fifo_data;
  logic [1:0]    fifo_count;
  logic          push, pop;
  assign ready_o = fifo_count != 2'd2;
  assign push = valid_i && ready_o;
  unpool_fifo2 #(.W(W)) u_fifo (
    .clk(clk), .rstn(rstn), .push_i(push), .pop_i(pop),
    .data_i(data_i), .data_o(fifo_data), .count_o(fifo_count)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
    end
  // A group end with a queued sample reloads hold directly so groups run back-to-back.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hold_d = hold_q;
    pop = 1'b0;
    case (state_q)
      IDLE: if (fifo_count != 2'd0) begin
        pop = 1'b1;
        hold_d = fifo_data;
        cnt_d = '0;
        state_d = EMIT;
      end
      EMIT: if (ready_i) begin
        if (cnt_q != LAST) cnt_d = cnt_q + 1'b1;
        else if (fifo_count != 2'd0) begin
          pop = 1'b1;
          hold_d = fifo_data;
          cnt_d = '0;
        end else begin
          cnt_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign valid_o = state_q == EMIT;
  assign last_o = valid_o && cnt_q == LAST;
`ifdef UNPOOL_ZERO_FILL_EN
  assign data_o = cnt_q == '0 ? hold_q : '0;
`else
  assign data_o = hold_q;
`endif
endmodule

// File: tb/tb_unpool_11.sv
// tb_unpool_11: self-checking bench for unpool_11 (table vectors, hand sequences, randomized scoreboard)
module tb_unpool_11;
  localparam int W = 28;
  localparam int P = 4;
  logic clk = 1'b0, rstn = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
  logic ready_o, valid_o, last_o;
  logic [W-1:0] data_i = '0, data_o;
  int checks = 0, errors = 0;

  unpool_11 dut (
    .clk(clk), .rstn(rstn), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .last_o(last_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] beat_val(input logic [W-1:0] h, input int b);
`ifdef UNPOOL_ZERO_FILL_EN
    return b == 0 ? h : '0;
`else
    return h;
`endif
  endfunction

  typedef struct {
    logic v; logic [W-1:0] d; logic r;
    logic ev; logic [W-1:0] eh; int eb; logic el; logic erdy;
  } vec_t;
  vec_t tbl[15];

  typedef struct { logic [W-1:0] d; logic l; } beat_t;
  beat_t sb[$];

  task automatic run_single(input logic [W-1:0] s, input string tag);
    @(negedge clk);
    valid_i = 1'b1; data_i = s; ready_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    check({tag, "_lat1_valid"}, W'(valid_o), W'(0));
    @(negedge clk);
    for (int b = 0; b < P; b++) begin
      check({tag, "_valid"}, W'(valid_o), W'(1));
      check({tag, "_data"}, data_o, beat_val(s, b));
      check({tag, "_last"}, W'(last_o), W'(b == P - 1));
      @(negedge clk);
    end
    check({tag, "_end_valid"}, W'(valid_o), W'(0));
  endtask

  initial begin
    logic pend, pv, pr, pl;
    logic [W-1:0] pd, pdat;
    int n;
    beat_t e;
    tbl[0]  = '{1'b1, 5, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 9, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 7, 1'b1, 1'b1, 5, 0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 0, 1'b1, 1'b1, 5, 1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 0, 1'b1, 1'b1, 5, 2, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 0, 1'b1, 1'b1, 5, 3, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 0, 1'b1, 1'b1, 9, 0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 0, 1'b1, 1'b1, 9, 1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 0, 1'b1, 1'b1, 9, 2, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 0, 1'b1, 1'b1, 9, 3, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 0, 1'b1, 1'b1, 7, 0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 0, 1'b1, 1'b1, 7, 1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 0, 1'b1, 1'b1, 7, 2, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 0, 1'b1, 1'b1, 7, 3, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_valid", W'(valid_o), W'(0));
    check("rst_last", W'(last_o), W'(0));
    check("rst_data", data_o, W'(0));
    check("rst_ready", W'(ready_o), W'(1));
    rstn = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      valid_i = tbl[i].v; data_i = tbl[i].d; ready_i = tbl[i].r;
      check($sformatf("tbl%0d_valid", i), W'(valid_o), W'(tbl[i].ev));
      check($sformatf("tbl%0d_ready", i), W'(ready_o), W'(tbl[i].erdy));
      if (tbl[i].ev) begin
        check($sformatf("tbl%0d_data", i), data_o, beat_val(tbl[i].eh, tbl[i].eb));
        check($sformatf("tbl%0d_last", i), W'(last_o), W'(tbl[i].el));
      end
    end

    run_single(W'('h123), "single");
    run_single(W'('hABC), "zf");

    @(negedge clk);
    valid_i = 1'b1; data_i = W'('h77); ready_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", W'(valid_o), W'(0));
    check("mid_rst_ready", W'(ready_o), W'(1));
    check("mid_rst_last", W'(last_o), W'(0));
    @(negedge clk);
    rstn = 1'b1;
    run_single(W'('h55), "post_rst");

    pend = 1'b0; pd = '0; pv = 1'b0; pr = 1'b1; pdat = '0; pl = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1'b1;
        pd = W'($urandom);
      end
      valid_i = pend; data_i = pd;
      ready_i = i < 60 ? (i % 3 == 0) : 1'($urandom_range(0, 1));
      if (pv && !pr) begin
        check("stall_valid", W'(valid_o), W'(1));
        check("stall_data", data_o, pdat);
        check("stall_last", W'(last_o), W'(pl));
      end
      if (valid_i && ready_o) begin
        for (int b = 0; b < P; b++) sb.push_back('{beat_val(pd, b), b == P - 1});
        pend = 1'b0;
      end
      if (valid_o && ready_i) begin
        if (sb.size() == 0) check("rnd_unexpected_beat", W'(1), W'(0));
        else begin
          e = sb.pop_front();
          check("rnd_data", data_o, e.d);
          check("rnd_last", W'(last_o), W'(e.l));
        end
      end
      pv = valid_o; pr = ready_i; pdat = data_o; pl = last_o;
    end

    @(negedge clk);
    valid_i = 1'b0; ready_i = 1'b1;
    n = 0;
    while ((sb.size() != 0 || valid_o) && n < 200) begin
      if (valid_o) begin
        if (sb.size() == 0) check("drain_unexpected_beat", W'(1), W'(0));
        else begin
          e = sb.pop_front();
          check("drain_data", data_o, e.d);
          check("drain_last", W'(last_o), W'(e.l));
        end
      end
      @(negedge clk);
      n++;
    end
    check("drain_left", W'(sb.size()), W'(0));
    check("drain_idle", W'(valid_o), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
